// File: rtl/alu_pkg.sv
// Shared ALU definitions: legal op codes, loader FSM state encodings
// and the per-button press-pulse bundle.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

  localparam logic [1:0] ST_WAIT_A  = 2'd0;
  localparam logic [1:0] ST_WAIT_B  = 2'd1;
  localparam logic [1:0] ST_WAIT_OP = 2'd2;
  localparam logic [1:0] ST_READY   = 2'd3;

  typedef struct packed {
    logic a;
    logic b;
    logic op;
  } btn_evt_t;

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-flop sync -> debounce counter -> one press pulse.
// Ports: clk, i_rst_n (sync, active-low), i_btn raw, o_pulse 1 cycle.
module btn_conditioner #(
  parameter int N_DEBOUNCE = 16
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int NB_CNT = $clog2(N_DEBOUNCE + 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(N_DEBOUNCE);

  logic              sync1;
  logic              sync2;
  logic [NB_CNT-1:0] cnt;
  logic              fired;

  // Pulse comes straight off the saturated count; fired blocks repeats
  // until the button drops low and re-qualifies.
  assign o_pulse = (cnt == CNT_MAX) && !fired;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      fired <= 1'b0;
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
      if (!sync2) begin
        cnt   <= '0;
        fired <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (o_pulse) fired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_input_loader.sv
// Loads ALU operands A, B and op code from switches on debounced presses.
// Ports: clk, i_rst_n, i_sw, i_btn_a/b/op in; o_dato_a/b, o_operation,
// o_valid, o_err (1-cycle reject pulse), o_state (debug) out.
module alu_input_loader
  import alu_pkg::*;
#(
  parameter int NB_DATA    = 4,
  parameter int NB_OP      = 6,
  parameter int NB_SW      = 8,
  parameter int N_DEBOUNCE = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid,
  output logic               o_err,
  output logic [1:0]         o_state
);

  btn_evt_t pulse;
  btn_evt_t sel;

  btn_conditioner #(.N_DEBOUNCE(N_DEBOUNCE)) u_btn_a (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_a),
    .o_pulse (pulse.a)
  );

  btn_conditioner #(.N_DEBOUNCE(N_DEBOUNCE)) u_btn_b (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_b),
    .o_pulse (pulse.b)
  );

  btn_conditioner #(.N_DEBOUNCE(N_DEBOUNCE)) u_btn_op (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_op),
    .o_pulse (pulse.op)
  );

  // Priority A > B > OP: lower-priority pulses in the same cycle are
  // dropped even if the winner is ignored in the current state.
  assign sel.a  = pulse.a;
  assign sel.b  = pulse.b & ~pulse.a;
  assign sel.op = pulse.op & ~pulse.a & ~pulse.b;

  logic [NB_DATA-1:0] sw_data;
  logic [NB_OP-1:0]   sw_op;
  logic               op_legal;

  assign sw_data = i_sw[NB_DATA-1:0];
  assign sw_op   = i_sw[NB_OP-1:0];

  assign op_legal = (sw_op == NB_OP'(OP_ADD)) ||
                    (sw_op == NB_OP'(OP_SUB)) ||
                    (sw_op == NB_OP'(OP_AND)) ||
                    (sw_op == NB_OP'(OP_OR))  ||
                    (sw_op == NB_OP'(OP_XOR)) ||
                    (sw_op == NB_OP'(OP_SRA)) ||
                    (sw_op == NB_OP'(OP_SRL)) ||
                    (sw_op == NB_OP'(OP_NOR));

  logic [1:0]         state;
  logic [1:0]         state_n;
  logic [NB_DATA-1:0] a_n;
  logic [NB_DATA-1:0] b_n;
  logic [NB_OP-1:0]   op_n;
  logic               err_n;

  always_comb begin
    state_n = state;
    a_n     = o_dato_a;
    b_n     = o_dato_b;
    op_n    = o_operation;
    err_n   = 1'b0;
    unique case (1'b1)
      sel.a: begin
        if (state == ST_WAIT_A || state == ST_READY) begin
          a_n     = sw_data;
          state_n = ST_WAIT_B;
        end
      end
      sel.b: begin
        if (state == ST_WAIT_B) begin
          b_n     = sw_data;
          state_n = ST_WAIT_OP;
        end else if (state == ST_READY) begin
          b_n = sw_data;
        end
      end
      sel.op: begin
        if (state == ST_WAIT_OP || state == ST_READY) begin
          if (op_legal) begin
            op_n    = sw_op;
            state_n = ST_READY;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state       <= ST_WAIT_A;
      o_dato_a    <= '0;
      o_dato_b    <= '0;
      o_operation <= '0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      o_dato_a    <= a_n;
      o_dato_b    <= b_n;
      o_operation <= op_n;
      o_valid     <= (state_n == ST_READY);
      o_err       <= err_n;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_alu_input_loader.sv
// Directed self-checking bench for alu_input_loader, N_DEBOUNCE=2.
module tb_alu_input_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn_a;
  logic       btn_b;
  logic       btn_op;
  logic [3:0] dato_a;
  logic [3:0] dato_b;
  logic [5:0] operation;
  logic       valid;
  logic       err;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;

  alu_input_loader #(
    .NB_DATA    (4),
    .NB_OP      (6),
    .NB_SW      (8),
    .N_DEBOUNCE (2)
  ) dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .i_sw        (sw),
    .i_btn_a     (btn_a),
    .i_btn_b     (btn_b),
    .i_btn_op    (btn_op),
    .o_dato_a    (dato_a),
    .o_dato_b    (dato_b),
    .o_operation (operation),
    .o_valid     (valid),
    .o_err       (err),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) err_cnt++;

  task automatic press(input logic pa, input logic pb,
                       input logic pop, input logic [7:0] s);
    @(negedge clk);
    sw = s; btn_a = pa; btn_b = pb; btn_op = pop;
    repeat (4) @(negedge clk);
    btn_a = 0; btn_b = 0; btn_op = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; sw = 8'hFF; btn_a = 0; btn_b = 0; btn_op = 0;
    repeat (3) @(negedge clk);
    total++;
    if (state !== 2'd0) begin
      bad++; $display("FAIL reset_state got=%0d exp=0", state);
    end
    total++;
    if ({dato_a, dato_b, operation} !== 14'd0) begin
      bad++;
      $display("FAIL reset_regs got=%h/%h/%h exp=0/0/0",
               dato_a, dato_b, operation);
    end
    total++;
    if ({valid, err} !== 2'b00) begin
      bad++; $display("FAIL reset_flags got=%b exp=00", {valid, err});
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrong_order();
    press(0, 1, 0, 8'h05);
    total++;
    if (dato_b !== 4'h0 || dato_a !== 4'h0) begin
      bad++; $display("FAIL b_first_regs got=%h/%h exp=0/0", dato_a, dato_b);
    end
    total++;
    if (state !== 2'd0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL b_first_state got=%0d/%b exp=0/0", state, valid);
    end
  endtask

  task automatic test_load_sequence();
    int e0;
    press(1, 0, 0, 8'h03);
    total++;
    if (dato_a !== 4'h3 || state !== 2'd1) begin
      bad++; $display("FAIL load_a got=%h/%0d exp=3/1", dato_a, state);
    end
    press(0, 1, 0, 8'h05);
    total++;
    if (dato_b !== 4'h5 || state !== 2'd2) begin
      bad++; $display("FAIL load_b got=%h/%0d exp=5/2", dato_b, state);
    end
    e0 = err_cnt;
    press(0, 0, 1, 8'h3F);
    total++;
    if (err_cnt - e0 !== 1) begin
      bad++; $display("FAIL illegal_err_cycles got=%0d exp=1", err_cnt - e0);
    end
    total++;
    if (operation !== 6'h00 || state !== 2'd2 || valid !== 1'b0) begin
      bad++;
      $display("FAIL illegal_hold got=%h/%0d/%b exp=00/2/0",
               operation, state, valid);
    end
    press(0, 0, 1, 8'h20);
    total++;
    if (operation !== 6'h20 || state !== 2'd3 || valid !== 1'b1) begin
      bad++;
      $display("FAIL load_op got=%h/%0d/%b exp=20/3/1",
               operation, state, valid);
    end
    total++;
    if (dato_a !== 4'h3 || dato_b !== 4'h5) begin
      bad++; $display("FAIL ready_ops got=%h/%h exp=3/5", dato_a, dato_b);
    end
  endtask

  task automatic test_debounce_latency();
    logic [3:0] prev;
    int first_k;
    int changes;
    @(negedge clk);
    sw = 8'h09; btn_b = 1;
    @(negedge clk);
    btn_b = 0;
    repeat (8) @(negedge clk);
    total++;
    if (dato_b !== 4'h5) begin
      bad++; $display("FAIL glitch_b got=%h exp=5", dato_b);
    end
    @(negedge clk);
    btn_b = 1;
    prev = dato_b; first_k = 0; changes = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (dato_b !== prev) begin
        changes++;
        if (first_k == 0) first_k = k;
        prev = dato_b;
      end
      if (k == 10) btn_b = 0;
    end
    total++;
    if (first_k !== 5) begin
      bad++; $display("FAIL latency_edges got=%0d exp=5", first_k);
    end
    total++;
    if (changes !== 1 || dato_b !== 4'h9) begin
      bad++; $display("FAIL held_b got=%0d/%h exp=1/9", changes, dato_b);
    end
    total++;
    if (state !== 2'd3 || valid !== 1'b1) begin
      bad++; $display("FAIL ready_b_hold got=%0d/%b exp=3/1", state, valid);
    end
  endtask

  task automatic test_ready_op();
    int e0;
    press(0, 0, 1, 8'h26);
    total++;
    if (operation !== 6'h26 || state !== 2'd3) begin
      bad++; $display("FAIL ready_op got=%h/%0d exp=26/3", operation, state);
    end
    e0 = err_cnt;
    press(0, 0, 1, 8'h01);
    total++;
    if (operation !== 6'h26 || err_cnt - e0 !== 1 || state !== 2'd3) begin
      bad++;
      $display("FAIL ready_illegal got=%h/%0d/%0d exp=26/1/3",
               operation, err_cnt - e0, state);
    end
  endtask

  task automatic test_simultaneous();
    int e0;
    e0 = err_cnt;
    press(1, 0, 1, 8'h24);
    total++;
    if (dato_a !== 4'h4 || state !== 2'd1 || valid !== 1'b0) begin
      bad++;
      $display("FAIL simul_a got=%h/%0d/%b exp=4/1/0", dato_a, state, valid);
    end
    total++;
    if (operation !== 6'h26 || err_cnt - e0 !== 0) begin
      bad++;
      $display("FAIL simul_op got=%h/%0d exp=26/0", operation, err_cnt - e0);
    end
  endtask

  task automatic test_reset_ready();
    press(0, 1, 0, 8'h07);
    press(0, 0, 1, 8'h27);
    total++;
    if (state !== 2'd3 || operation !== 6'h27 || dato_b !== 4'h7) begin
      bad++;
      $display("FAIL nor_ready got=%0d/%h/%h exp=3/27/7",
               state, operation, dato_b);
    end
    @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    total++;
    if ({state, dato_a, dato_b, operation, valid, err} !== 18'd0) begin
      bad++;
      $display("FAIL reset_ready got=%0d/%h/%h/%h/%b/%b exp=all 0",
               state, dato_a, dato_b, operation, valid, err);
    end
  endtask

  task automatic test_reset_mid_press();
    logic [3:0] prev;
    int first_k;
    @(negedge clk);
    sw = 8'h0C; btn_a = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    prev = dato_a; first_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (dato_a !== prev && first_k == 0) first_k = k;
      prev = dato_a;
      if (k == 8) btn_a = 0;
    end
    total++;
    if (first_k !== 5) begin
      bad++; $display("FAIL midpress_latency got=%0d exp=5", first_k);
    end
    total++;
    if (dato_a !== 4'hC || state !== 2'd1) begin
      bad++; $display("FAIL midpress_load got=%h/%0d exp=c/1", dato_a, state);
    end
  endtask

  initial begin
    test_reset();
    test_wrong_order();
    test_load_sequence();
    test_debounce_latency();
    test_ready_op();
    test_simultaneous();
    test_reset_ready();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_input_loader.md
ALU_INPUT_LOADER -- requirements
Module: alu_input_loader

Interface
REQ-001 Parameter NB_DATA, default 4: operand width; matches the ALU data width.
REQ-002 Parameter NB_OP, default 6: operation-code width; matches the ALU op width.
REQ-003 Parameter NB_SW, default 8: switch-bank width; SHALL be >= max(NB_DATA, NB_OP).
REQ-004 Parameter N_DEBOUNCE, default 16: number of consecutive stable-high cycles that qualify a button press.
REQ-005 clk  input  1  Single clock; all state updates on its rising edge.
REQ-006 i_rst_n  input  1  Reset, synchronous, active-low.
REQ-007 i_sw  input  NB_SW  Raw switch bank; operator holds it steady during a press.
REQ-008 i_btn_a  input  1  Raw button; loads operand A.
REQ-009 i_btn_b  input  1  Raw button; loads operand B.
REQ-010 i_btn_op  input  1  Raw button; loads the operation code.
REQ-011 o_dato_a  output  NB_DATA  Registered operand A; drives the ALU i_datoA.
REQ-012 o_dato_b  output  NB_DATA  Registered operand B; drives the ALU i_datoB.
REQ-013 o_operation  output  NB_OP  Registered op code; drives the ALU i_operation.
REQ-014 o_valid  output  1  High while A, B and a legal op are all loaded; drives the ALU i_valid.
REQ-015 o_err  output  1  One-cycle pulse when an illegal op code is rejected.
REQ-016 o_state  output  2  Current FSM state encoding, for debug LEDs.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter.
REQ-018 Debounce counter SHALL clear on any synchronized-low cycle and saturate at N_DEBOUNCE.
REQ-019 A one-cycle press pulse SHALL fire when the counter reaches N_DEBOUNCE; no further pulse until the button is released (sync low) and re-qualified.
REQ-020 Load latency SHALL be fixed: the register updates at the edge ending the pulse cycle, 2+N_DEBOUNCE+1 edges after raw high is first sampled.
REQ-021 Operands SHALL load i_sw[NB_DATA-1:0]; the op code SHALL load i_sw[NB_OP-1:0]; switches are sampled on the load edge, unsynchronized.
REQ-022 FSM states: WAIT_A=0, WAIT_B=1, WAIT_OP=2, READY=3; o_state SHALL equal the current state.
REQ-023 WAIT_A: press A -> load A, go to WAIT_B; presses B and OP are ignored.
REQ-024 WAIT_B: press B -> load B, go to WAIT_OP; presses A and OP are ignored.
REQ-025 WAIT_OP: legal press OP -> load op, go to READY; illegal code -> op unchanged, o_err pulses, state held.
REQ-026 Legal codes are exactly ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
REQ-027 READY, press A: reload A, go to WAIT_B, o_valid deasserts.
REQ-028 READY, press B: reload B, stay in READY with o_valid held high.
REQ-029 READY, legal OP: reload op, stay in READY.
REQ-030 READY, illegal OP: keep the old op, pulse o_err, stay in READY.
REQ-031 Simultaneous pulses: only the highest-priority one acts (A > B > OP); the others are dropped.
REQ-032 o_valid SHALL be registered and high exactly while the state is READY.
REQ-033 Outputs SHALL never change except on a load or reset; o_err is also driven low in every non-error cycle.

Reset
REQ-034 While i_rst_n=0 at a clock edge: state=WAIT_A; o_dato_a=0, o_dato_b=0, o_operation=0; o_valid=0, o_err=0; synchronizers and debounce counters cleared.
REQ-035 Reset mid-press: the held button SHALL re-qualify through the full debounce time after release of reset.

Structure
REQ-036 A shared package alu_pkg SHALL hold the op-code localparams (OP_ADD..OP_NOR) and the FSM state encodings; the ALU uses the same package.
REQ-037 One sub-module, btn_conditioner (synchronizer + debounce + edge pulse), SHALL be instantiated three times.

Verification (N_DEBOUNCE=2)
REQ-038 Sequence: sw=0011 press A; sw=0101 press B; sw=100000 press OP -> A=0011, B=0101, op=100000, valid=1, state=3.
REQ-039 Press B first from WAIT_A -> no register change, state stays 0, valid=0.
REQ-040 In WAIT_OP, sw=111111 press OP -> err pulse exactly 1 cycle, op=0, state stays 2.
REQ-041 Button glitch high 1 cycle -> no load; button held 10 cycles -> exactly one load at latency 5 edges.
REQ-042 In READY, A and OP pressed simultaneously -> A reloaded, state=1, valid=0, op unchanged.
REQ-043 Reset asserted while in READY -> at the next edge all outputs are 0 and state=0.
